// File: rtl/vdp_script_pkg.sv
// Shared definitions for the VDP I/O script player: opcode encodings,
// script entry layout and the player state encoding.
package vdp_script_pkg;

    // Script entry layout: {op[19:18], port[17:16], data[15:8], aux[7:0]}
    localparam int ENTRY_W = 20;
    localparam int OP_HI   = 19;
    localparam int OP_LO   = 18;
    localparam int PORT_HI = 17;
    localparam int PORT_LO = 16;
    localparam int DATA_HI = 15;
    localparam int DATA_LO = 8;
    localparam int AUX_HI  = 7;
    localparam int AUX_LO  = 0;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_POLL  = 2'd1,
        OP_DELAY = 2'd2,
        OP_END   = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_WRITE     = 3'd3,
        ST_READ_REQ  = 3'd4,
        ST_READ_WAIT = 3'd5,
        ST_DELAY     = 3'd6,
        ST_FINISH    = 3'd7
    } state_e;

    // Field order matches the raw entry so a plain cast unpacks it.
    typedef struct packed {
        op_e        op;
        logic [1:0] port;
        logic [7:0] data;
        logic [7:0] aux;
    } entry_t;

    // A poll succeeds when every bit selected by the mask agrees.
    function automatic logic poll_match(input logic [7:0] rdata,
                                        input logic [7:0] expect_val,
                                        input logic [7:0] mask);
        return ((rdata & mask) == (expect_val & mask));
    endfunction

endpackage

// File: rtl/vdp_io_script_player.sv
// Plays a small script of VDP port writes, masked polls and delays out of an
// external script memory, one entry at a time, until an END entry or a poll
// timeout. All outputs are registered.
module vdp_io_script_player
    import vdp_script_pkg::*;
#(
    parameter int SCRIPT_AW   = 8,
    parameter int TIMEOUT_W   = 20,
    parameter int TIMEOUT_MAX = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [SCRIPT_AW-1:0] script_address,
    input  logic [19:0]          script_rdata,
    output logic [1:0]           bus_address,
    output logic                 bus_valid,
    output logic                 bus_write,
    output logic [7:0]           bus_wdata,
    input  logic                 bus_ready,
    input  logic [7:0]           bus_rdata,
    input  logic                 bus_rdata_en
);

    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_MAX);
    localparam logic [SCRIPT_AW-1:0] PTR_ONE   = SCRIPT_AW'(1);

    state_e               state_q, state_d;
    logic [SCRIPT_AW-1:0] ptr_q, ptr_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic [15:0]          delay_q, delay_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           aux_q, aux_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 bus_valid_q, bus_valid_d;
    logic                 bus_write_q, bus_write_d;
    logic [1:0]           bus_address_q, bus_address_d;
    logic [7:0]           bus_wdata_q, bus_wdata_d;

    entry_t               entry_s;
    logic                 match_s;
    logic [TIMEOUT_W-1:0] tmo_inc_s;
    logic                 tmo_expire_s;

    assign entry_s      = entry_t'(script_rdata);
    assign match_s      = poll_match(bus_rdata, data_q, aux_q);
    assign tmo_inc_s    = tmo_q + TIMEOUT_W'(1);
    assign tmo_expire_s = (tmo_inc_s == TMO_LIMIT);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            tmo_q         <= '0;
            delay_q       <= 16'd0;
            data_q        <= 8'd0;
            aux_q         <= 8'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            bus_valid_q   <= 1'b0;
            bus_write_q   <= 1'b0;
            bus_address_q <= 2'd0;
            bus_wdata_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            tmo_q         <= tmo_d;
            delay_q       <= delay_d;
            data_q        <= data_d;
            aux_q         <= aux_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            bus_valid_q   <= bus_valid_d;
            bus_write_q   <= bus_write_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
        end
    end

    // Next-state selection for the playback sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (entry_s.op)
                    OP_WRITE: state_d = ST_WRITE;
                    OP_POLL:  state_d = ST_READ_REQ;
                    OP_DELAY: state_d = ST_DELAY;
                    OP_END:   state_d = ST_FINISH;
                    default:  state_d = ST_FINISH;
                endcase
            end
            ST_WRITE: begin
                if (bus_ready) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ_REQ: begin
                if (bus_ready) begin
                    state_d = ST_READ_WAIT;
                end else begin
                    state_d = ST_READ_REQ;
                end
            end
            ST_READ_WAIT: begin
                if (!bus_rdata_en) begin
                    state_d = ST_READ_WAIT;
                end else if (match_s) begin
                    state_d = ST_FETCH;
                end else if (tmo_expire_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_READ_REQ;
                end
            end
            ST_DELAY: begin
                if (delay_q == 16'd0) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DELAY;
                end
            end
            ST_FINISH: begin
                // A start arriving together with done is dropped here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath updates and next values of the registered outputs.
    always_comb begin
        ptr_d         = ptr_q;
        tmo_d         = tmo_q;
        delay_d       = delay_q;
        data_d        = data_q;
        aux_d         = aux_q;
        error_d       = error_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;

        // Handshake-visible flags follow the state being entered, so the
        // request is on the bus for exactly the cycles spent in WRITE/READ_REQ.
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_FINISH);
        done_d      = (state_d == ST_FINISH);
        bus_valid_d = (state_d == ST_WRITE) || (state_d == ST_READ_REQ);
        bus_write_d = (state_d == ST_WRITE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_d   = '0;
                    tmo_d   = '0;
                    delay_d = 16'd0;
                    error_d = 1'b0;
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_DECODE: begin
                data_d = entry_s.data;
                aux_d  = entry_s.aux;
                case (entry_s.op)
                    OP_WRITE: begin
                        bus_address_d = entry_s.port;
                        bus_wdata_d   = entry_s.data;
                    end
                    OP_POLL: begin
                        bus_address_d = entry_s.port;
                        tmo_d         = '0;
                    end
                    OP_DELAY: begin
                        delay_d = {entry_s.data, entry_s.aux};
                    end
                    OP_END: begin
                        ptr_d = ptr_q;
                    end
                    default: begin
                        ptr_d = ptr_q;
                    end
                endcase
            end
            ST_WRITE: begin
                if (bus_ready) begin
                    ptr_d = ptr_q + PTR_ONE;
                end else begin
                    ptr_d = ptr_q;
                end
            end
            ST_READ_WAIT: begin
                if (!bus_rdata_en) begin
                    ptr_d = ptr_q;
                end else if (match_s) begin
                    ptr_d = ptr_q + PTR_ONE;
                end else begin
                    tmo_d = tmo_inc_s;
                    if (tmo_expire_s) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                end
            end
            ST_DELAY: begin
                if (delay_q == 16'd0) begin
                    ptr_d = ptr_q + PTR_ONE;
                end else begin
                    delay_d = delay_q - 16'd1;
                end
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign script_address = ptr_q;
    assign bus_address    = bus_address_q;
    assign bus_valid      = bus_valid_q;
    assign bus_write      = bus_write_q;
    assign bus_wdata      = bus_wdata_q;

endmodule

// File: tb/tb_vdp_io_script_player.sv
// Self-checking bench for vdp_io_script_player: script memory and bus
// responders, a transaction-level model of script execution, and a single
// monitor that compares every bus handshake and done pulse with the model.
module tb_vdp_io_script_player;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int TMAX  = 4;
    localparam int NRESP = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, error;
    logic [AW-1:0] script_address;
    logic [19:0]   script_rdata = 20'd0;
    logic [1:0]    bus_address;
    logic          bus_valid, bus_write;
    logic [7:0]    bus_wdata;
    logic          bus_ready;
    logic [7:0]    bus_rdata;
    logic          bus_rdata_en;

    always #5 clk = ~clk;

    vdp_io_script_player #(
        .SCRIPT_AW  (AW),
        .TIMEOUT_W  (8),
        .TIMEOUT_MAX(TMAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .script_address(script_address),
        .script_rdata  (script_rdata),
        .bus_address   (bus_address),
        .bus_valid     (bus_valid),
        .bus_write     (bus_write),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .bus_rdata_en  (bus_rdata_en)
    );

    typedef struct packed {
        logic       wr;
        logic [1:0] port;
        logic [7:0] data;
    } txn_t;

    logic [19:0] mem  [DEPTH];
    logic [7:0]  resp [NRESP];
    txn_t        exp_q[$];
    logic        exp_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int mode = 0;
    bit no_resp = 1'b0;
    bit pending = 1'b0;
    int lat = 0;
    int ridx = 0;
    bit prev_stall = 1'b0;
    logic [10:0] prev_bus = 11'd0;
    int vrun = 0;
    int vcount = 0;
    int first_valid_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    bit prev_done = 1'b0;
    int start_cyc = 0;
    txn_t mon_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [19:0] ent(input int op, input int port, input int data, input int aux);
        return {2'(op), 2'(port), 8'(data), 8'(aux)};
    endfunction

    // Script memory: data appears one cycle after the address.
    always @(posedge clk) script_rdata <= mem[script_address];

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level model: walk the script and list the bus handshakes.
    task automatic build_model();
        int ptr, ri, steps, tries;
        bit fin, matched;
        logic [19:0] e;
        logic [1:0] op, port;
        logic [7:0] d, a, v;
        ptr = 0; ri = 0; steps = 0; fin = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        while (!fin && steps < 2000) begin
            steps++;
            e = mem[ptr];
            op = e[19:18]; port = e[17:16]; d = e[15:8]; a = e[7:0];
            if (op == 2'd0) begin
                exp_q.push_back({1'b1, port, d});
                ptr = (ptr + 1) % DEPTH;
            end else if (op == 2'd1) begin
                tries = 0; matched = 1'b0;
                while (!matched && !fin) begin
                    exp_q.push_back({1'b0, port, 8'h00});
                    if (ri >= NRESP) begin
                        fin = 1'b1;
                    end else begin
                        v = resp[ri]; ri++;
                        if ((v & a) == (d & a)) matched = 1'b1;
                        else begin
                            tries++;
                            if (tries == TMAX) begin exp_err = 1'b1; fin = 1'b1; end
                        end
                    end
                end
                if (matched) ptr = (ptr + 1) % DEPTH;
            end else if (op == 2'd2) begin
                ptr = (ptr + 1) % DEPTH;
            end else begin
                fin = 1'b1;
            end
        end
    endtask

    function automatic int count_reads();
        int n = 0;
        foreach (exp_q[i]) if (!exp_q[i].wr) n++;
        return n;
    endfunction

    // Bus responder and the single compare process, both on the falling edge.
    always @(negedge clk) begin
        bus_rdata_en = 1'b0;
        if (reset) begin
            pending = 1'b0; vrun = 0; prev_stall = 1'b0; prev_done = 1'b0;
            bus_ready = 1'b0;
        end else begin
            if (pending) begin
                if (lat == 0) begin
                    if (!no_resp) begin
                        bus_rdata_en = 1'b1;
                        bus_rdata = resp[ridx % NRESP];
                        ridx++;
                        pending = 1'b0;
                    end
                end else begin
                    lat--;
                end
            end else if (mode == 1 && $urandom_range(0, 7) == 0) begin
                bus_rdata_en = 1'b1;
                bus_rdata = 8'($urandom);
            end
            case (mode)
                0: bus_ready = 1'b1;
                1: bus_ready = ($urandom_range(0, 9) < 7);
                2: bus_ready = (vrun >= 5);
                default: bus_ready = 1'b1;
            endcase
            if (prev_stall) begin
                chk("hold_valid", 32'(bus_valid), 32'd1);
                chk("hold_payload", 32'({bus_write, bus_address, bus_wdata}), 32'(prev_bus));
            end
            if (bus_valid) begin
                vcount++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (bus_valid && bus_ready) begin
                chk("txn_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_t = exp_q.pop_front();
                    chk("txn_dir", 32'(bus_write), 32'(mon_t.wr));
                    chk("txn_port", 32'(bus_address), 32'(mon_t.port));
                    if (mon_t.wr) chk("txn_wdata", 32'(bus_wdata), 32'(mon_t.data));
                end
                if (!bus_write) begin
                    pending = 1'b1;
                    lat = (mode == 1) ? $urandom_range(0, 3) : 0;
                end
                prev_stall = 1'b0; vrun = 0;
            end else if (bus_valid) begin
                prev_stall = 1'b1;
                prev_bus = {bus_write, bus_address, bus_wdata};
                vrun++;
            end else begin
                prev_stall = 1'b0; vrun = 0;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("done_busy_low", 32'(busy), 32'd0);
                chk("done_error", 32'(error), 32'(exp_err));
                chk("done_single_cycle", 32'(prev_done), 32'd0);
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Start a playback, wait for done, poke start during done, check the end state.
    task automatic run(input int m);
        int n0, t;
        mode = m;
        build_model();
        ridx = 0; done_cyc = -1; first_valid_cyc = -1; vcount = 0;
        n0 = done_cnt;
        tick();
        start = 1'b1; start_cyc = cyc;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_error_clear", 32'(error), 32'd0);
        t = 0;
        while (done_cnt == n0 && t < 3000) begin tick(); t++; end
        chk("done_within_budget", 32'(done_cnt != n0), 32'd1);
        if (done_cnt == n0) begin
            reset = 1'b1; tick(); reset = 1'b0;
            exp_q.delete();
        end else begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick(); tick();
            chk("start_with_done_ignored", 32'(busy), 32'd0);
            chk("done_pulses", 32'(done_cnt - n0), 32'd1);
            chk("error_final", 32'(error), 32'(exp_err));
            chk("txns_left", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        int len, k, n0, t;
        reset = 1'b1; start = 1'b0; bus_ready = 1'b0; bus_rdata = 8'd0; bus_rdata_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = ent(3, 0, 0, 0);
        for (int i = 0; i < NRESP; i++) resp[i] = 8'd0;
        repeat (3) tick();
        chk("reset_outputs", 32'({busy, done, error, bus_valid, bus_write, bus_address, bus_wdata, script_address}), 32'd0);
        reset = 1'b0;

        // Two writes then END, bus always ready.
        mem[0] = ent(0, 1, 8'h0A, 0); mem[1] = ent(0, 1, 8'h80, 0); mem[2] = ent(3, 0, 0, 0);
        build_model();
        chk("model_end_txns", 32'(exp_q.size()), 32'd2);
        chk("model_end_first", 32'(exp_q[0].data), 32'h0A);
        run(0);
        chk("end_done_latency", 32'(done_cyc - start_cyc - 1), 32'd8);

        // Single write stalled five cycles.
        mem[0] = ent(0, 0, 8'hC3, 0); mem[1] = ent(3, 0, 0, 0);
        run(2);
        chk("stall_valid_cycles", 32'(vcount), 32'd6);

        // Poll that matches on the fourth read, then a write.
        mem[0] = ent(1, 1, 8'h00, 8'h01); mem[1] = ent(0, 2, 8'h77, 0); mem[2] = ent(3, 0, 0, 0);
        resp[0] = 8'h01; resp[1] = 8'h01; resp[2] = 8'h01; resp[3] = 8'h00;
        build_model();
        chk("model_poll_reads", 32'(count_reads()), 32'd4);
        run(0);

        // Poll that never matches: timeout abort.
        mem[0] = ent(1, 1, 8'h00, 8'h01); mem[1] = ent(3, 0, 0, 0);
        for (int i = 0; i < NRESP; i++) resp[i] = 8'h01;
        build_model();
        chk("model_timeout_reads", 32'(count_reads()), 32'd4);
        chk("model_timeout_err", 32'(exp_err), 32'd1);
        run(0);

        // DELAY of 3 then a write.
        mem[0] = ent(2, 0, 8'h00, 8'h03); mem[1] = ent(0, 2, 8'h55, 0); mem[2] = ent(3, 0, 0, 0);
        run(0);
        chk("delay_first_valid", 32'(first_valid_cyc - start_cyc - 1), 32'd8);
        chk("delay_done_latency", 32'(done_cyc - start_cyc - 1), 32'd11);
        chk("delay_valid_cycles", 32'(vcount), 32'd1);

        // Pointer wrap: entry 0 polls, 1..15 write, wrap back to entry 0 which times out.
        mem[0] = ent(1, 0, 8'h5A, 8'hFF);
        for (int i = 1; i < DEPTH; i++) mem[i] = ent(0, i % 4, i, 0);
        for (int i = 0; i < NRESP; i++) resp[i] = 8'h00;
        resp[0] = 8'h5A;
        build_model();
        chk("model_wrap_txns", 32'(exp_q.size()), 32'd20);
        run(1);

        // Reset while waiting for read data, then replay from entry 0.
        for (int i = 0; i < DEPTH; i++) mem[i] = ent(3, 0, 0, 0);
        mem[0] = ent(0, 3, 8'h33, 0); mem[1] = ent(1, 0, 8'h00, 8'hFF); mem[2] = ent(3, 0, 0, 0);
        resp[0] = 8'h00;
        mode = 0; no_resp = 1'b1;
        build_model();
        tick(); start = 1'b1; tick(); start = 1'b0;
        t = 0;
        while (!pending && t < 100) begin tick(); t++; end
        chk("rst_reached_read", 32'(pending), 32'd1);
        tick(); tick();
        n0 = done_cnt;
        reset = 1'b1;
        tick();
        chk("rst_mid_outputs", 32'({busy, done, error, bus_valid, bus_write, bus_address, bus_wdata, script_address}), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_no_done", 32'(done_cnt - n0), 32'd0);
        no_resp = 1'b0;
        exp_q.delete();
        run(0);

        // Randomized scripts.
        for (int it = 0; it < 30; it++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < DEPTH; i++) mem[i] = ent(3, 0, 0, 0);
            for (int i = 0; i < len; i++) begin
                k = $urandom_range(0, 2);
                if (k == 0) mem[i] = ent(0, $urandom_range(0, 3), $urandom_range(0, 255), 0);
                else if (k == 1) mem[i] = ent(1, $urandom_range(0, 3), $urandom_range(0, 255),
                                              ($urandom_range(0, 3) == 0) ? 0 : (1 << $urandom_range(0, 7)));
                else mem[i] = ent(2, 0, 0, $urandom_range(0, 7));
            end
            for (int i = 0; i < NRESP; i++) resp[i] = 8'($urandom);
            run(($urandom_range(0, 3) == 0) ? 0 : 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/vdp_io_script_player.md
VDP_IO_SCRIPT_PLAYER -- requirements
Module: vdp_io_script_player

Interface
REQ-001 SHALL have parameter SCRIPT_AW, default 8, meaning script address width (up to 2^SCRIPT_AW entries).
REQ-002 SHALL have parameter TIMEOUT_W, default 20, meaning poll timeout counter width.
REQ-003 SHALL have parameter TIMEOUT_MAX, default 1000000, meaning poll attempts before abort.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, meaning one-cycle pulse that begins playback at entry 0; ignored while busy.
REQ-007 SHALL have ports busy, done and error, each output, 1, meaning player active, one-cycle completion pulse and sticky timeout flag respectively.
REQ-008 SHALL have port script_address, output, SCRIPT_AW, meaning script memory read address.
REQ-009 SHALL have port script_rdata, input, 20, meaning entry {op[19:18], port[17:16], data[15:8], aux[7:0]}, valid 1 cycle after script_address.
REQ-010 SHALL have ports bus_address (output, 2, VDP port 0-3), bus_valid (output, 1), bus_write (output, 1), bus_wdata (output, 8) and bus_ready (input, 1), together forming the VDP I/O request channel.
REQ-011 SHALL have ports bus_rdata (input, 8) and bus_rdata_en (input, 1, pulse marking bus_rdata valid).

Function
REQ-012 SHALL decode op 0 as WRITE: data is written to port.
REQ-013 SHALL decode op 1 as POLL: port is read until (rdata & aux) == (data & aux).
REQ-014 SHALL decode op 2 as DELAY: wait {data,aux}+1 cycles.
REQ-015 SHALL decode op 3 as END.
REQ-016 SHALL implement states IDLE, FETCH, DECODE, WRITE, READ_REQ, READ_WAIT, DELAY and FINISH.
REQ-017 SHALL transition IDLE->FETCH on start, with entry pointer 0, error cleared and busy=1 from the next cycle.
REQ-018 SHALL spend 1 cycle in FETCH presenting the pointer on script_address, then advance to DECODE, which samples script_rdata.
REQ-019 SHALL, in WRITE, hold bus_valid=1, bus_write=1, bus_address and bus_wdata stable until the cycle bus_ready=1, then increment the pointer and go to FETCH.
REQ-020 SHALL, in READ_REQ, hold bus_valid=1, bus_write=0 until bus_ready=1, then go to READ_WAIT.
REQ-021 SHALL, in READ_WAIT, compare bus_rdata on bus_rdata_en: on match, increment the pointer and go to FETCH; on mismatch, increment the timeout counter and return to READ_REQ.
REQ-022 SHALL, when the timeout counter reaches TIMEOUT_MAX, set error=1 and go to FINISH.
REQ-023 SHALL clear the timeout counter at each POLL entry decode.
REQ-024 SHALL count the DELAY down from {data,aux}, leaving on zero, so that DELAY 0 lasts 1 cycle.
REQ-025 SHALL handle END or FINISH by pulsing done for 1 cycle, setting busy=0 and returning to IDLE.
REQ-026 SHALL wrap the pointer from 2^SCRIPT_AW-1 to 0 without error; an END entry is the only normal termination.
REQ-027 SHALL never assert bus_valid outside WRITE and READ_REQ.
REQ-028 SHALL ignore bus_rdata_en outside READ_WAIT.
REQ-029 SHALL ignore a start pulse arriving in the same cycle as done; playback restarts only from IDLE.

Reset
REQ-030 SHALL, on reset, force state IDLE; busy, done, error, bus_valid and bus_write = 0; and bus_address, bus_wdata, script_address and all counters = 0.
REQ-031 SHALL let reset asserted mid-transaction drop bus_valid on the following edge with no done pulse.

Structure
REQ-032 SHALL place op encodings, the entry field positions and the state enum in shared package vdp_script_pkg.
REQ-033 SHALL keep the poll timeout and delay counters in this module; no sub-module is required.

Verification
REQ-034 SHALL verify: script {WRITE p1 0x0A, WRITE p1 0x80, END} with bus_ready tied 1 -> exactly two bus writes to port 1 (0x0A then 0x80), done 1 cycle after END decode, error=0.
REQ-035 SHALL verify: WRITE with bus_ready held 0 for 5 cycles -> bus_valid and data stable for 6 cycles, single write accepted.
REQ-036 SHALL verify: POLL p1 mask 0x01 expect 0x00; rdata 0x01 three times then 0x00 -> four reads issued, then next entry fetched, error=0.
REQ-037 SHALL verify: POLL never matching with TIMEOUT_MAX=4 -> exactly 4 reads, error=1, done pulse, busy=0.
REQ-038 SHALL verify: DELAY {0x00,0x03} -> 4 cycles in DELAY, no bus_valid during the delay.
REQ-039 SHALL verify: reset asserted during READ_WAIT -> next cycle state IDLE, all outputs 0, and a subsequent start replays from entry 0.
